// File: rtl/ser_pkg.sv
// ser_pkg: definitions shared by the serializer and the downstream
// serial-in shift register.
//   state_t       - serializer FSM states
//   DEFAULT_WIDTH - word width both stages agree on
//   cnt_width()   - bit-counter width for a given word width, max(1, clog2(w))
package ser_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int unsigned DEFAULT_WIDTH = 6;

  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/piso_hold_reg.sv
// piso_hold_reg: one-entry buffer holding the next word while the current
// word is still shifting.
//   i_clk, i_rst_n - clock, asynchronous active-low reset
//   i_wr, i_wdata  - capture i_wdata and mark the buffer full
//   i_clr          - mark the buffer empty (word handed to the shifter)
//   o_data, o_full - buffered word and its full flag
module piso_hold_reg #(
  parameter int unsigned WIDTH = 6
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_clr,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full
);

  logic [WIDTH-1:0] r_data;
  logic             r_full;

  // i_wr needs the buffer empty and i_clr needs it full, so they never coincide.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data <= '0;
      r_full <= 1'b0;
    end else if (i_wr) begin
      r_data <= i_wdata;
      r_full <= 1'b1;
    end else if (i_clr) begin
      r_full <= 1'b0;
    end
  end

  assign o_data = r_data;
  assign o_full = r_full;

endmodule

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in/serial-out stage with valid/ready load
// handshake and framing strobes; a hold buffer lets words stream gap-free.
//   clk, rst                  - clock, asynchronous active-low reset
//   pdata, load_valid         - parallel word offer
//   load_ready                - a word can be accepted this cycle
//   dout, dout_valid          - serial bit and its qualifier
//   frame_start, frame_done   - first / last bit of a word on dout
//   busy                      - shifting or hold buffer occupied
module piso_serializer
  import ser_pkg::*;
#(
  parameter int unsigned WIDTH      = DEFAULT_WIDTH,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter bit          IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pdata,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             frame_start,
  output logic             frame_done,
  output logic             busy
);

  localparam int unsigned    CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

  state_t           r_state, w_next_state;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shifted;
  logic [WIDTH-1:0] w_hold_data;
  logic [CW-1:0]    r_cnt;
  logic             w_hold_full;
  logic             w_xfer;
  logic             w_last;
  logic             w_hold_wr;
  logic             w_hold_clr;

  assign load_ready = rst & ~w_hold_full;
  assign w_xfer     = load_valid & load_ready;
  assign w_last     = (r_cnt == LAST_CNT);
  assign w_shifted  = MSB_FIRST ? {r_shift[WIDTH-2:0], 1'b0}
                                : {1'b0, r_shift[WIDTH-1:1]};
  // Only transfers before the last-bit edge go to the hold buffer; a transfer
  // on the last-bit edge (hold empty) loads the shifter directly.
  assign w_hold_wr  = w_xfer && (r_state == SHIFT) && !w_last;
  assign w_hold_clr = (r_state == SHIFT) && w_last && w_hold_full;
  assign busy       = (r_state == SHIFT) | w_hold_full;

  piso_hold_reg #(
    .WIDTH (WIDTH)
  ) u_hold (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_wr    (w_hold_wr),
    .i_wdata (pdata),
    .i_clr   (w_hold_clr),
    .o_data  (w_hold_data),
    .o_full  (w_hold_full)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    dout         = IDLE_LEVEL;
    dout_valid   = 1'b0;
    frame_start  = 1'b0;
    frame_done   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_xfer) w_next_state = SHIFT;
      end
      SHIFT: begin
        dout        = MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];
        dout_valid  = 1'b1;
        frame_start = (r_cnt == '0);
        frame_done  = w_last;
        if (w_last && !w_hold_full && !w_xfer) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_xfer) begin
            r_shift <= pdata;
            r_cnt   <= '0;
          end
        end
        SHIFT: begin
          if (!w_last) begin
            r_shift <= w_shifted;
            r_cnt   <= r_cnt + 1'b1;
          end else if (w_hold_full) begin
            r_shift <= w_hold_data;
            r_cnt   <= '0;
          end else if (w_xfer) begin
            r_shift <= pdata;
            r_cnt   <= '0;
          end else begin
            r_shift <= '0;
            r_cnt   <= '0;
          end
        end
        default: begin
          r_shift <= '0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;

  logic [5:0] pdata = '0;
  logic       load_valid = 1'b0;
  logic       load_ready, dout, dout_valid, frame_start, frame_done, busy;

  logic [5:0] l_pdata = '0;
  logic       l_load_valid = 1'b0;
  logic       l_load_ready, l_dout, l_dout_valid, l_frame_start, l_frame_done, l_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  piso_serializer #(
    .WIDTH      (6),
    .MSB_FIRST  (1'b1),
    .IDLE_LEVEL (1'b0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pdata       (pdata),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .busy        (busy)
  );

  piso_serializer #(
    .WIDTH      (6),
    .MSB_FIRST  (1'b0),
    .IDLE_LEVEL (1'b0)
  ) dut_lsb (
    .clk         (clk),
    .rst         (rst),
    .pdata       (l_pdata),
    .load_valid  (l_load_valid),
    .load_ready  (l_load_ready),
    .dout        (l_dout),
    .dout_valid  (l_dout_valid),
    .frame_start (l_frame_start),
    .frame_done  (l_frame_done),
    .busy        (l_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst        = 1'b0;
    load_valid = 1'b1;
    pdata      = 6'b101101;
    tick();
    tick();
    checks++;
    if ({dout, dout_valid, load_ready, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs: got dout/dv/ready/busy=%b expected 0000",
               {dout, dout_valid, load_ready, busy});
    end
    rst        = 1'b1;
    load_valid = 1'b0;
    tick();
    checks++;
    if ({load_ready, dout_valid, busy} !== 3'b100) begin
      errors++;
      $display("FAIL reset_release: got ready/dv/busy=%b expected 100",
               {load_ready, dout_valid, busy});
    end
  endtask

  task automatic test_single_word();
    logic [5:0] w;
    w          = 6'b101101;
    pdata      = w;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      checks++;
      if ({dout, dout_valid, frame_start, frame_done} !== {w[5-k], 1'b1, k == 0, k == 5}) begin
        errors++;
        $display("FAIL single_bit%0d: got dout/dv/fs/fd=%b expected %b", k,
                 {dout, dout_valid, frame_start, frame_done}, {w[5-k], 1'b1, k == 0, k == 5});
      end
      tick();
    end
    checks++;
    if ({dout, dout_valid, busy} !== 3'b000) begin
      errors++;
      $display("FAIL single_after: got dout/dv/busy=%b expected 000", {dout, dout_valid, busy});
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] s;
    s          = 12'b110001_001110;
    pdata      = 6'b110001;
    load_valid = 1'b1;
    tick();
    for (int k = 0; k < 12; k++) begin
      checks++;
      if ({dout, dout_valid, frame_start, frame_done} !==
          {s[11-k], 1'b1, (k == 0) || (k == 6), (k == 5) || (k == 11)}) begin
        errors++;
        $display("FAIL b2b_bit%0d: got dout/dv/fs/fd=%b expected %b", k,
                 {dout, dout_valid, frame_start, frame_done},
                 {s[11-k], 1'b1, (k == 0) || (k == 6), (k == 5) || (k == 11)});
      end
      checks++;
      if (load_ready !== ((k == 0) || (k > 5))) begin
        errors++;
        $display("FAIL b2b_ready%0d: got %b expected %b", k, load_ready, (k == 0) || (k > 5));
      end
      if (k == 0) pdata = 6'b001110;
      if (k == 5) load_valid = 1'b0;
      tick();
      // Garbage offered while the hold buffer is full must be ignored.
      if (k == 0) pdata = 6'b111111;
    end
    checks++;
    if ({dout_valid, busy} !== 2'b00) begin
      errors++;
      $display("FAIL b2b_after: got dv/busy=%b expected 00", {dout_valid, busy});
    end
  endtask

  task automatic test_last_edge_load();
    logic [11:0] s;
    s          = 12'b100110_011011;
    pdata      = 6'b100110;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    for (int k = 0; k < 12; k++) begin
      checks++;
      if ({dout, dout_valid, frame_start, frame_done} !==
          {s[11-k], 1'b1, (k == 0) || (k == 6), (k == 5) || (k == 11)}) begin
        errors++;
        $display("FAIL last_edge_bit%0d: got dout/dv/fs/fd=%b expected %b", k,
                 {dout, dout_valid, frame_start, frame_done},
                 {s[11-k], 1'b1, (k == 0) || (k == 6), (k == 5) || (k == 11)});
      end
      if (k == 5) begin
        checks++;
        if (load_ready !== 1'b1) begin
          errors++;
          $display("FAIL last_edge_ready: got %b expected 1", load_ready);
        end
        pdata      = 6'b011011;
        load_valid = 1'b1;
      end
      tick();
      load_valid = 1'b0;
    end
    checks++;
    if ({dout, dout_valid} !== 2'b00) begin
      errors++;
      $display("FAIL last_edge_after: got dout/dv=%b expected 00", {dout, dout_valid});
    end
  endtask

  task automatic test_reset_mid_word();
    logic [5:0] w;
    pdata      = 6'b111000;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    tick();
    tick();
    checks++;
    if ({dout, dout_valid} !== 2'b11) begin
      errors++;
      $display("FAIL midrst_before: got dout/dv=%b expected 11", {dout, dout_valid});
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({dout, dout_valid, busy, load_ready} !== 4'b0000) begin
      errors++;
      $display("FAIL midrst_async: got dout/dv/busy/ready=%b expected 0000",
               {dout, dout_valid, busy, load_ready});
    end
    tick();
    rst = 1'b1;
    tick();
    w          = 6'b010101;
    pdata      = w;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      checks++;
      if ({dout, dout_valid, frame_start, frame_done} !== {w[5-k], 1'b1, k == 0, k == 5}) begin
        errors++;
        $display("FAIL midrst_bit%0d: got dout/dv/fs/fd=%b expected %b", k,
                 {dout, dout_valid, frame_start, frame_done}, {w[5-k], 1'b1, k == 0, k == 5});
      end
      tick();
    end
  endtask

  task automatic test_lsb_first();
    logic [5:0] exp_bits;
    exp_bits     = 6'b000011;
    l_pdata      = 6'b000011;
    l_load_valid = 1'b1;
    tick();
    l_load_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      checks++;
      if ({l_dout, l_dout_valid, l_frame_start, l_frame_done} !==
          {exp_bits[k], 1'b1, k == 0, k == 5}) begin
        errors++;
        $display("FAIL lsb_bit%0d: got dout/dv/fs/fd=%b expected %b", k,
                 {l_dout, l_dout_valid, l_frame_start, l_frame_done},
                 {exp_bits[k], 1'b1, k == 0, k == 5});
      end
      tick();
    end
    checks++;
    if ({l_dout, l_dout_valid, l_busy} !== 3'b000) begin
      errors++;
      $display("FAIL lsb_after: got dout/dv/busy=%b expected 000", {l_dout, l_dout_valid, l_busy});
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_last_edge_load();
    test_reset_mid_word();
    test_lsb_first();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in/serial-out stage directly upstream of the team's 6-bit serial-in shift register; its dout drives that block's din.
- Accepts parallel words through a valid/ready handshake and emits one bit per clock, with framing strobes.
- A one-entry hold buffer lets consecutive words stream with no idle bit between them.

Parameters:
WIDTH, 6, word width in bits; must be at least 2.
MSB_FIRST, 1, 1 shifts out MSB first; 0 shifts out LSB first.
IDLE_LEVEL, 0, value driven on dout when no word is being shifted.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset
pdata  input  WIDTH  parallel word to serialize
load_valid  input  1  pdata is valid this cycle
load_ready  output  1  block can accept a word this cycle
dout  output  1  serial bit, feeds downstream din
dout_valid  output  1  dout carries a payload bit
frame_start  output  1  dout carries bit 0 of a word
frame_done  output  1  dout carries the last bit of a word
busy  output  1  high when in SHIFT or when the hold buffer is full

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. Clock port is clk; reset port is rst (active-low).
- Reset, applied asynchronously while rst=0:
  - state=IDLE, hold buffer empty, shift register=0, bit counter=0.
  - dout=IDLE_LEVEL; dout_valid, frame_start, frame_done, busy and load_ready all 0.
  - load_ready rises on the first clk cycle after rst is released.
- Handshake:
  - A transfer occurs on any rising edge with load_valid=1 and load_ready=1.
  - load_ready = rst released AND hold buffer empty. It is registered-state derived, with no combinational path from load_valid.
  - pdata is sampled only on a transfer edge.
- States and transitions:
  - IDLE: on a transfer, load pdata into the shift register, set counter=0, go to SHIFT.
  - SHIFT: dout = shift_reg[WIDTH-1] if MSB_FIRST, else shift_reg[0]; dout_valid=1.
  - SHIFT: frame_start=1 when counter=0; frame_done=1 when counter=WIDTH-1.
  - SHIFT, each edge with counter<WIDTH-1: shift toward the output end, zero-fill, counter+1.
  - A transfer during SHIFT, before the last-bit edge, writes pdata into the hold buffer.
- Last-bit edge (counter=WIDTH-1), in priority order:
  1. Hold buffer full: move hold into shift_reg, counter=0, stay in SHIFT, empty hold. A transfer is impossible on this edge because load_ready=0.
  2. Hold empty and a transfer occurs: load pdata directly into shift_reg, counter=0, stay in SHIFT.
  3. Otherwise: go to IDLE.
- Latency and outputs:
  - First bit appears on dout in the cycle after the transfer edge.
  - A word occupies exactly WIDTH consecutive dout_valid cycles.
  - dout=IDLE_LEVEL whenever dout_valid=0.
- Counter width is max(1, $clog2(WIDTH)) bits. The counter never exceeds WIDTH-1 and wraps only through an explicit reload to 0.
- Reset mid-word aborts the word and any held word; there is no partial completion.
- load_valid asserted while load_ready=0: no effect, and the word is not captured.
- All outputs are glitch-free functions of registered state, except load_ready, which also depends on rst.

Decomposition:
- Shared package ser_pkg holds:
  - the state typedef (IDLE, SHIFT);
  - the counter-width constant function;
  - the default WIDTH=6 constant, so the upstream and downstream stages agree.
- No sub-module is required. The hold buffer (data plus full flag) may optionally be split into piso_hold_reg. Everything else stays in one module.

Test Plan:
1. Reset: hold rst=0 for 2 cycles with load_valid=1 -> dout=0, dout_valid=0, load_ready=0, nothing captured. After release, load_ready=1 on the next cycle.
2. Single word, MSB_FIRST=1: pdata=6'b101101 transferred at edge E -> dout=1,0,1,1,0,1 in cycles E+1..E+6, frame_start only at E+1, frame_done only at E+6. At E+7: dout=0, dout_valid=0, busy=0.
3. Back-to-back: 6'b110001 then 6'b001110, load_valid held high -> 12 contiguous dout_valid cycles giving 110001001110. load_ready is low while the hold buffer is full. frame_done pulses twice, 6 cycles apart.
4. Last-edge direct load: second word 6'b011011 presented only on the last-bit edge of the first word, with hold empty -> accepted; first bit follows the prior last bit with no gap.
5. Reset mid-word: assert rst after 3 bits of 6'b111000 -> dout drops to 0 asynchronously. After release, 6'b010101 serializes cleanly from bit 0 with frame_start=1.
6. LSB_FIRST (MSB_FIRST=0): pdata=6'b000011 -> dout=1,1,0,0,0,0.
